id_ex_forward_reg: RTL and testbench
====================================

Name: id_ex_forward_reg

Overview:
- ID/EX pipeline register for the 5-stage MIPS core; sits directly upstream of the EX-stage operand muxes.
- Latches decoded operands and control from ID.
- Pre-computes the 2-bit forward selects one cycle early, so EX muxes see registered selects.
- Detects load-use hazards: stalls PC/IF-ID and inserts a bubble.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_W, 5, register-address width
- ALUOP_W, 4, ALU op code width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- inFlush  in  1  kill ID instruction (taken branch/jump)
- inRs, inRt, inRd  in  REG_W each  ID register fields
- inUsesRs, inUsesRt  in  1 each  instruction reads rs/rt
- inDataRs, inDataRt  in  DATA_W each  register-file read data
- inSignExt  in  DATA_W  sign-extended immediate
- inRegWrite, inMemRead, inMemWrite, inMemToReg, inAluSrc, inRegDst  in  1 each  ID control
- inAluOp  in  ALUOP_W  ALU operation
- inMemRegWrite  in  1  EX/MEM stage writes regfile
- inMemWriteReg  in  REG_W  EX/MEM destination register
- outDataRs, outDataRt, outSignExt  out  DATA_W each  latched operands
- outWriteReg  out  REG_W  latched destination (inRegDst ? inRd : inRt)
- outRegWrite, outMemRead, outMemWrite, outMemToReg  out  1 each  latched control
- outAluOp  out  ALUOP_W  latched ALU op
- outForwardA  out  2  select for operand A
- outForwardB  out  2  select for operand B
- outForwardStore  out  2  select for store data
- outValid  out  1  EX holds a real instruction
- outStall  out  1  combinational; hold PC and IF/ID

Behaviour:
- Forward encoding (fixed):
  - 00 = regfile data
  - 10 = EX/MEM ALU result
  - 01 = MEM/WB write-back mux
  - 11 = sign-extended immediate (B only)
- Reset:
  - All outputs are 0 on the first clk edge with reset high, including selects=00, outValid=0, outStall=0.
  - Reset mid-stream discards the in-flight instruction.
- Per-operand select, for an ID source register s with its uses flag (computed combinationally, registered on clk):
  - 10 if outValid & outRegWrite & !outMemRead & outWriteReg==s & s!=0
  - else 01 if inMemRegWrite & inMemWriteReg==s & s!=0
  - else 00
  - The EX instruction becomes MEM next cycle; the MEM instruction becomes WB.
  - If the uses flag is 0, the select is 00.
- outForwardA: the select for rs.
- outForwardB:
  - 11 when inAluSrc=1.
  - Otherwise the select for rt.
- outForwardStore: always the select for rt (gated by inUsesRt), independent of inAluSrc.
- Register-file same-cycle write/read is handled by the regfile (write first half); no WB-to-ID path is needed here.
- outStall is asserted when all of the following hold:
  - inFlush=0
  - outValid & outMemRead & outWriteReg!=0
  - (inUsesRs & inRs==outWriteReg) | (inUsesRt & inRt==outWriteReg)
- Register update each edge, by priority:
  1. reset
  2. inFlush or outStall → bubble: all control 0, outValid=0, selects 00; data fields may hold any value.
  3. Otherwise latch all ID inputs and computed selects; outValid=1.
- Stall recovery:
  - The stall lasts exactly one cycle: the bubble clears outMemRead.
  - On the recompute, the load sits in MEM, so the dependent operand gets select 01.
- Latency: 1 cycle ID→EX. No combinational path from ID data inputs to outputs; outStall is the only combinational output.
- Simultaneous flush and hazard: flush wins; outStall=0.

Optional Feature:
- Macro: HAZARD_STATS_EN
- Defined:
  - Adds outStallCount and outFlushCount (32 bits each).
  - They increment on every edge where outStall / inFlush is sampled high.
  - Cleared by reset; wrap at 2^32-1 → 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset held 2 cycles, then released → all outputs 0, outStall=0; first non-stalled instruction gives outValid=1 one edge later.
- EX: add $3 (RegWrite); ID: sub reading rs=$3 → next cycle outForwardA=10, outForwardB=00.
- MEM: inMemRegWrite=1, inMemWriteReg=5; ID: addi rs=$5, inAluSrc=1 → outForwardA=01, outForwardB=11.
- EX: lw $4; ID: add rt=$4:
  - outStall=1 for one cycle; next edge gives outValid=0 bubble.
  - Following edge gives outForwardB=01, outValid=1.
- ID: sw rt=$2 with MEM writing $2 and EX writing $2 (non-load) → outForwardB=11, outForwardStore=10 (EX/MEM priority).
- Dependence on $0 in EX and MEM → all selects 00. Load-use hazard with inFlush=1 → outStall=0, bubble latched.

Source files
------------

// File: rtl/id_ex_forward_reg_if.sv
// ID/EX boundary bundle: ID-stage decode results and MEM-stage write-back info in,
// latched EX-stage operands, control and forward selects out.
interface id_ex_forward_reg_if #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 4
);
    logic               inFlush;
    logic [REG_W-1:0]   inRs, inRt, inRd;
    logic               inUsesRs, inUsesRt;
    logic [DATA_W-1:0]  inDataRs, inDataRt, inSignExt;
    logic               inRegWrite, inMemRead, inMemWrite, inMemToReg, inAluSrc, inRegDst;
    logic [ALUOP_W-1:0] inAluOp;
    logic               inMemRegWrite;
    logic [REG_W-1:0]   inMemWriteReg;

    logic [DATA_W-1:0]  outDataRs, outDataRt, outSignExt;
    logic [REG_W-1:0]   outWriteReg;
    logic               outRegWrite, outMemRead, outMemWrite, outMemToReg;
    logic [ALUOP_W-1:0] outAluOp;
    logic [1:0]         outForwardA, outForwardB, outForwardStore;
    logic               outValid;
    logic               outStall;
`ifdef HAZARD_STATS_EN
    logic [31:0]        outStallCount, outFlushCount;
`endif

    modport slave (
        input  inFlush, inRs, inRt, inRd, inUsesRs, inUsesRt,
               inDataRs, inDataRt, inSignExt,
               inRegWrite, inMemRead, inMemWrite, inMemToReg, inAluSrc, inRegDst,
               inAluOp, inMemRegWrite, inMemWriteReg,
        output outDataRs, outDataRt, outSignExt, outWriteReg,
               outRegWrite, outMemRead, outMemWrite, outMemToReg, outAluOp,
               outForwardA, outForwardB, outForwardStore, outValid, outStall
`ifdef HAZARD_STATS_EN
             , outStallCount, outFlushCount
`endif
    );

    modport master (
        output inFlush, inRs, inRt, inRd, inUsesRs, inUsesRt,
               inDataRs, inDataRt, inSignExt,
               inRegWrite, inMemRead, inMemWrite, inMemToReg, inAluSrc, inRegDst,
               inAluOp, inMemRegWrite, inMemWriteReg,
        input  outDataRs, outDataRt, outSignExt, outWriteReg,
               outRegWrite, outMemRead, outMemWrite, outMemToReg, outAluOp,
               outForwardA, outForwardB, outForwardStore, outValid, outStall
`ifdef HAZARD_STATS_EN
             , outStallCount, outFlushCount
`endif
    );
endinterface

// File: rtl/id_ex_forward_reg.sv
// ID/EX pipeline register with registered forward selects and load-use stall detection.
// Define HAZARD_STATS_EN to add 32-bit stall/flush event counters.
module id_ex_forward_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 4
) (
    input logic clk,
    input logic reset,
    id_ex_forward_reg_if.slave bus
);
    logic [DATA_W-1:0]  r_dataRs_p1, r_dataRt_p1, r_signExt_p1;
    logic [REG_W-1:0]   r_writeReg_p1;
    logic               r_regWrite_p1, r_memRead_p1, r_memWrite_p1, r_memToReg_p1;
    logic [ALUOP_W-1:0] r_aluOp_p1;
    logic [1:0]         r_fwdA_p1, r_fwdB_p1, r_fwdStore_p1;
    logic               r_vld_p1;

    logic [1:0]         w_fwdRs, w_fwdRt, w_fwdB;
    logic [REG_W-1:0]   w_writeReg;
    logic               w_hazard, w_stall, w_bubble;

    // EX-stage result wins over MEM-stage write-back; loads in EX have no result yet.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] s, input logic uses);
        fwd_sel = 2'b00;
        if (uses && (s != '0)) begin
            if (r_vld_p1 && r_regWrite_p1 && !r_memRead_p1 && (r_writeReg_p1 == s))
                fwd_sel = 2'b10;
            else if (bus.inMemRegWrite && (bus.inMemWriteReg == s))
                fwd_sel = 2'b01;
        end
    endfunction

    always_comb begin
        w_fwdRs    = fwd_sel(bus.inRs, bus.inUsesRs);
        w_fwdRt    = fwd_sel(bus.inRt, bus.inUsesRt);
        w_fwdB     = bus.inAluSrc ? 2'b11 : w_fwdRt;
        w_writeReg = bus.inRegDst ? bus.inRd : bus.inRt;
        w_hazard   = r_vld_p1 && r_memRead_p1 && (r_writeReg_p1 != '0) &&
                     ((bus.inUsesRs && (bus.inRs == r_writeReg_p1)) ||
                      (bus.inUsesRt && (bus.inRt == r_writeReg_p1)));
        w_stall    = !bus.inFlush && w_hazard;
        w_bubble   = bus.inFlush || w_stall;
    end

    // ID -> EX boundary: control path, bubbled on flush or stall
    always_ff @(posedge clk) begin
        if (reset || w_bubble) begin
            r_vld_p1      <= 1'b0;
            r_regWrite_p1 <= 1'b0;
            r_memRead_p1  <= 1'b0;
            r_memWrite_p1 <= 1'b0;
            r_memToReg_p1 <= 1'b0;
            r_aluOp_p1    <= '0;
            r_fwdA_p1     <= 2'b00;
            r_fwdB_p1     <= 2'b00;
            r_fwdStore_p1 <= 2'b00;
        end else begin
            r_vld_p1      <= 1'b1;
            r_regWrite_p1 <= bus.inRegWrite;
            r_memRead_p1  <= bus.inMemRead;
            r_memWrite_p1 <= bus.inMemWrite;
            r_memToReg_p1 <= bus.inMemToReg;
            r_aluOp_p1    <= bus.inAluOp;
            r_fwdA_p1     <= w_fwdRs;
            r_fwdB_p1     <= w_fwdB;
            r_fwdStore_p1 <= w_fwdRt;
        end
    end

    // ID -> EX boundary: data path, don't-care while a bubble is in EX
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dataRs_p1   <= '0;
            r_dataRt_p1   <= '0;
            r_signExt_p1  <= '0;
            r_writeReg_p1 <= '0;
        end else begin
            r_dataRs_p1   <= bus.inDataRs;
            r_dataRt_p1   <= bus.inDataRt;
            r_signExt_p1  <= bus.inSignExt;
            r_writeReg_p1 <= w_writeReg;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stallCnt, r_flushCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (w_stall)     r_stallCnt <= r_stallCnt + 32'd1;
            if (bus.inFlush) r_flushCnt <= r_flushCnt + 32'd1;
        end
    end

    assign bus.outStallCount = r_stallCnt;
    assign bus.outFlushCount = r_flushCnt;
`endif

    assign bus.outDataRs       = r_dataRs_p1;
    assign bus.outDataRt       = r_dataRt_p1;
    assign bus.outSignExt      = r_signExt_p1;
    assign bus.outWriteReg     = r_writeReg_p1;
    assign bus.outRegWrite     = r_regWrite_p1;
    assign bus.outMemRead      = r_memRead_p1;
    assign bus.outMemWrite     = r_memWrite_p1;
    assign bus.outMemToReg     = r_memToReg_p1;
    assign bus.outAluOp        = r_aluOp_p1;
    assign bus.outForwardA     = r_fwdA_p1;
    assign bus.outForwardB     = r_fwdB_p1;
    assign bus.outForwardStore = r_fwdStore_p1;
    assign bus.outValid        = r_vld_p1;
    assign bus.outStall        = w_stall;
endmodule

// File: tb/tb_id_ex_forward_reg.sv
// Directed bench for id_ex_forward_reg: expected EX-stage contents queued per step, checked after the edge.
module tb_id_ex_forward_reg;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   n = 0;

    always #5 clk = ~clk;

    id_ex_forward_reg_if bus ();

    id_ex_forward_reg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  fa, fb, fs;
        logic        v, rw, mr, mw, mtr;
        logic [3:0]  al;
        logic [4:0]  wr;
        bit          cd;
        logic [31:0] drs, drt, imm;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (step %0d)", tag, obs, exp, n);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] fa, fb, fs, input logic v, rw, mr, mw, mtr,
                                input logic [3:0] al, input logic [4:0] wr, input bit cd);
        exp_t e;
        e.fa = fa; e.fb = fb; e.fs = fs; e.v = v; e.rw = rw; e.mr = mr; e.mw = mw; e.mtr = mtr;
        e.al = al; e.wr = wr; e.cd = cd; e.drs = '0; e.drt = '0; e.imm = '0;
        return e;
    endfunction

    function automatic exp_t bub();
        return mk(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 1'b0);
    endfunction

    task automatic id(input logic [4:0] rs, rt, rd, input logic urs, urt, rw, mr, mw, mtr, asrc, rdst,
                      input logic [3:0] al);
        bus.inRs = rs; bus.inRt = rt; bus.inRd = rd; bus.inUsesRs = urs; bus.inUsesRt = urt;
        bus.inRegWrite = rw; bus.inMemRead = mr; bus.inMemWrite = mw; bus.inMemToReg = mtr;
        bus.inAluSrc = asrc; bus.inRegDst = rdst; bus.inAluOp = al;
    endtask

    task automatic mem(input logic rw, input logic [4:0] wr);
        bus.inMemRegWrite = rw;
        bus.inMemWriteReg = wr;
    endtask

    task automatic step(input exp_t e, input logic exp_stall, input bit do_stall);
        exp_t got;
        n++;
        bus.inDataRs  = 32'h1000_0000 + n;
        bus.inDataRt  = 32'h2000_0000 + n;
        bus.inSignExt = 32'hFFFF_F000 + n;
        if (reset) begin
            e.drs = '0; e.drt = '0; e.imm = '0;
        end else begin
            e.drs = bus.inDataRs; e.drt = bus.inDataRt; e.imm = bus.inSignExt;
        end
        sb.push_back(e);
        #1;
        if (do_stall) chk("outStall", bus.outStall, exp_stall);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("outForwardA", bus.outForwardA, got.fa);
        chk("outForwardB", bus.outForwardB, got.fb);
        chk("outForwardStore", bus.outForwardStore, got.fs);
        chk("outValid", bus.outValid, got.v);
        chk("outRegWrite", bus.outRegWrite, got.rw);
        chk("outMemRead", bus.outMemRead, got.mr);
        chk("outMemWrite", bus.outMemWrite, got.mw);
        chk("outMemToReg", bus.outMemToReg, got.mtr);
        chk("outAluOp", bus.outAluOp, got.al);
        if (got.cd) begin
            chk("outWriteReg", bus.outWriteReg, got.wr);
            chk("outDataRs", bus.outDataRs, got.drs);
            chk("outDataRt", bus.outDataRt, got.drt);
            chk("outSignExt", bus.outSignExt, got.imm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at step %0d", n);
        $fatal(1, "bench did not finish");
    end

    initial begin
        reset = 1'b1;
        bus.inFlush = 1'b0;
        id(5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 0, 0, 0, 1, 4'h2);
        mem(1'b0, 5'd0);
        // Two reset edges: everything zero, ID contents ignored
        step(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 4'h0, 5'd0, 1), 1'b0, 1'b0);
        step(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 4'h0, 5'd0, 1), 1'b0, 1'b1);

        // add $3,$1,$2 : first valid instruction
        reset = 1'b0;
        step(mk(2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 0, 4'h2, 5'd3, 1), 1'b0, 1'b1);
        // sub $6,$3,$7 : rs hits EX add -> A=10
        id(5'd3, 5'd7, 5'd6, 1, 1, 1, 0, 0, 0, 0, 1, 4'h6);
        step(mk(2'b10, 2'b00, 2'b00, 1, 1, 0, 0, 0, 4'h6, 5'd6, 1), 1'b0, 1'b1);
        // addi $8,$5,imm with MEM writing $5 -> A=01, B=11
        id(5'd5, 5'd8, 5'd0, 1, 0, 1, 0, 0, 0, 1, 0, 4'h3);
        mem(1'b1, 5'd5);
        step(mk(2'b01, 2'b11, 2'b00, 1, 1, 0, 0, 0, 4'h3, 5'd8, 1), 1'b0, 1'b1);
        // lw $4,0($9)
        id(5'd9, 5'd4, 5'd0, 1, 0, 1, 1, 0, 1, 1, 0, 4'h8);
        mem(1'b1, 5'd6);
        step(mk(2'b00, 2'b11, 2'b00, 1, 1, 1, 0, 1, 4'h8, 5'd4, 1), 1'b0, 1'b1);
        // add $10,$11,$4 : load-use -> stall, bubble
        id(5'd11, 5'd4, 5'd10, 1, 1, 1, 0, 0, 0, 0, 1, 4'h2);
        mem(1'b1, 5'd8);
        step(bub(), 1'b1, 1'b1);
        // same add again, load now in MEM -> B=01, store=01
        mem(1'b1, 5'd4);
        step(mk(2'b00, 2'b01, 2'b01, 1, 1, 0, 0, 0, 4'h2, 5'd10, 1), 1'b0, 1'b1);
        // add $2,$12,$13
        id(5'd12, 5'd13, 5'd2, 1, 1, 1, 0, 0, 0, 0, 1, 4'h2);
        mem(1'b0, 5'd0);
        step(mk(2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 0, 4'h2, 5'd2, 1), 1'b0, 1'b1);
        // sw $2,4($14) with EX and MEM both writing $2 -> B=11, store=10
        id(5'd14, 5'd2, 5'd0, 1, 1, 0, 0, 1, 0, 1, 0, 4'h9);
        mem(1'b1, 5'd2);
        step(mk(2'b00, 2'b11, 2'b10, 1, 0, 0, 1, 0, 4'h9, 5'd2, 1), 1'b0, 1'b1);
        // add $0,$0,$0 with MEM writing $0
        id(5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0, 0, 0, 1, 4'h2);
        mem(1'b1, 5'd0);
        step(mk(2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 0, 4'h2, 5'd0, 1), 1'b0, 1'b1);
        // add $15,$0,$0 with EX and MEM writing $0 -> no forwarding
        id(5'd0, 5'd0, 5'd15, 1, 1, 1, 0, 0, 0, 0, 1, 4'h2);
        step(mk(2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 0, 4'h2, 5'd15, 1), 1'b0, 1'b1);
        // lw $4 again
        id(5'd9, 5'd4, 5'd0, 1, 0, 1, 1, 0, 1, 1, 0, 4'h8);
        mem(1'b0, 5'd0);
        step(mk(2'b00, 2'b11, 2'b00, 1, 1, 1, 0, 1, 4'h8, 5'd4, 1), 1'b0, 1'b1);
        // dependent add with flush: no stall, bubble
        id(5'd11, 5'd4, 5'd10, 1, 1, 1, 0, 0, 0, 0, 1, 4'h2);
        bus.inFlush = 1'b1;
        step(bub(), 1'b0, 1'b1);
        // after flush bubble, load in MEM -> B=01
        bus.inFlush = 1'b0;
        mem(1'b1, 5'd4);
        step(mk(2'b00, 2'b01, 2'b01, 1, 1, 0, 0, 0, 4'h2, 5'd10, 1), 1'b0, 1'b1);
`ifdef HAZARD_STATS_EN
        chk("outStallCount", bus.outStallCount, 32'd1);
        chk("outFlushCount", bus.outFlushCount, 32'd1);
`endif
        // mid-stream reset discards the ID instruction
        reset = 1'b1;
        id(5'd10, 5'd3, 5'd20, 1, 1, 1, 0, 0, 0, 0, 1, 4'h2);
        mem(1'b0, 5'd0);
        step(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 4'h0, 5'd0, 1), 1'b0, 1'b1);
`ifdef HAZARD_STATS_EN
        chk("outStallCount_rst", bus.outStallCount, 32'd0);
        chk("outFlushCount_rst", bus.outFlushCount, 32'd0);
`endif
        // add $20,$10,$3 : EX empty after reset -> no forwarding
        reset = 1'b0;
        step(mk(2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 0, 4'h2, 5'd20, 1), 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
